// File: rtl/music_pkg.sv
// Shared types and defaults for the music fader slice.
// Envelope state encoding, default widths/timing, and a prescaler
// width helper that stays valid when the step period is a single clock.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } fade_state_t;

  localparam int LEVEL_W_DEF  = 4;
  localparam int STEP_CYC_DEF = 4096;

  // Counter width able to hold 0..step_cyc-1; never narrower than one bit.
  function automatic int presc_width(input int step_cyc);
    return (step_cyc > 1) ? $clog2(step_cyc) : 1;
  endfunction

endpackage

// File: rtl/music_pwm.sv
// PWM volume gate for the fader.
// A free-running LEVEL_W-bit counter is compared against the envelope
// level; the square wave is gated by that compare and registered, so
// the speaker output lags tone_in by exactly one clock.
module music_pwm #(
  parameter int LEVEL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_tone,
  input  logic [LEVEL_W-1:0] i_level,
  output logic               o_spk
);

  logic [LEVEL_W-1:0] r_pwm_cnt;
  logic               r_spk;
  logic               w_gate;

  // Level 0 never opens the gate; the top level leaves one slot closed.
  assign w_gate = (r_pwm_cnt < i_level);

  // Free-running PWM counter and registered gated speaker output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_cnt <= '0;
      r_spk     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_spk     <= i_tone & w_gate;
    end
  end

  assign o_spk = r_spk;

endmodule

// File: rtl/music_fader.sv
// Attack/sustain/release volume envelope between the melody player and
// the speaker pin. Drives the player's enable (mflug_out) and holds it
// through the release tail so notes fade instead of cutting off.
// Optional build macro: MUSIC_FADER_VOLCAP_EN adds a 'vol' input that
// caps the envelope level; without it the cap is all ones.
// state_dbg mirrors the envelope state register for observation.
module music_fader
  import music_pkg::*;
#(
  parameter int LEVEL_W  = LEVEL_W_DEF,
  parameter int STEP_CYC = STEP_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic               tone_in,
`ifdef MUSIC_FADER_VOLCAP_EN
  input  logic [LEVEL_W-1:0] vol,
`endif
  output logic               mflug_out,
  output logic               spk,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output fade_state_t        state_dbg
);

  localparam int                PRESC_W    = presc_width(STEP_CYC);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_CYC - 1);

  fade_state_t        r_state;
  logic [LEVEL_W-1:0] r_level;
  logic               r_busy;
  logic [PRESC_W-1:0] r_presc;

  logic               w_step;
  logic [LEVEL_W-1:0] w_cap;
  logic [LEVEL_W-1:0] w_level_inc;
  logic [LEVEL_W-1:0] w_level_dec;

`ifdef MUSIC_FADER_VOLCAP_EN
  assign w_cap = vol;
`else
  assign w_cap = '1;
`endif

  // The increment is only used while r_level < w_cap and the decrement
  // only while r_level > 0, so neither can wrap.
  assign w_level_inc = r_level + 1'b1;
  assign w_level_dec = r_level - 1'b1;
  assign w_step      = (r_presc == PRESC_LAST);

  // Envelope step prescaler: parked at 0 while idle so every attack
  // from idle gets a full first step period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (r_state == IDLE) begin
      r_presc <= '0;
    end else if (w_step) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Envelope FSM: level ramps one step per prescaler period; busy is the
  // registered (state != IDLE), so enable drops one clock after the
  // release tail reaches level 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_level <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= (r_state != IDLE);
      case (r_state)
        IDLE: begin
          r_level <= '0;
          if (play) begin
            r_state <= ATTACK;
          end
        end
        ATTACK: begin
          if (!play) begin
            r_state <= RELEASE;
          end else if (r_level >= w_cap) begin
            // Already at or above the cap (cap of 0, or re-trigger above
            // a lowered cap): sustain takes care of any ramp down.
            r_state <= SUSTAIN;
          end else if (w_step) begin
            r_level <= w_level_inc;
            if (w_level_inc == w_cap) begin
              r_state <= SUSTAIN;
            end
          end
        end
        SUSTAIN: begin
          if (!play) begin
            r_state <= RELEASE;
          end else if (w_step && (r_level > w_cap)) begin
            r_level <= w_level_dec;
          end
        end
        RELEASE: begin
          if (play) begin
            // Re-trigger resumes the attack from the current level.
            r_state <= ATTACK;
          end else if (r_level == '0) begin
            r_state <= IDLE;
          end else if (w_step) begin
            r_level <= w_level_dec;
            if (w_level_dec == '0) begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_level <= '0;
        end
      endcase
    end
  end

  music_pwm #(
    .LEVEL_W (LEVEL_W)
  ) u_pwm (
    .clk     (clk),
    .reset   (reset),
    .i_tone  (tone_in),
    .i_level (r_level),
    .o_spk   (spk)
  );

  assign mflug_out = r_busy;
  assign busy      = r_busy;
  assign level     = r_level;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_music_fader.sv
// Directed bench for music_fader with LEVEL_W=4, STEP_CYC=4.
// Inputs change and outputs are sampled on the falling clock edge.
// Edge numbers in comments count rising edges since reset was released.
module tb_music_fader;
  import music_pkg::*;

  localparam int LW = 4;
  localparam int SC = 4;

  logic          clk;
  logic          reset;
  logic          play;
  logic          tone_in;
`ifdef MUSIC_FADER_VOLCAP_EN
  logic [LW-1:0] vol;
`endif
  logic          mflug_out;
  logic          spk;
  logic [LW-1:0] level;
  logic          busy;
  fade_state_t   state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  music_fader #(
    .LEVEL_W  (LW),
    .STEP_CYC (SC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .tone_in   (tone_in),
`ifdef MUSIC_FADER_VOLCAP_EN
    .vol       (vol),
`endif
    .mflug_out (mflug_out),
    .spk       (spk),
    .level     (level),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input fade_state_t exp);
    check(tag, 32'(state_dbg), 32'(exp));
  endtask

  initial begin
    int cnt;
    logic t_prev;
    logic exp_spk;

    reset   = 1'b1;
    play    = 1'b1;
    tone_in = 1'b1;
`ifdef MUSIC_FADER_VOLCAP_EN
    vol     = 4'hF;
`endif

    // Reset held three cycles with play high: everything stays cleared.
    repeat (3) begin
      tick();
      check("rst_spk", spk, 0);
      check("rst_mflug", mflug_out, 0);
      check("rst_level", level, 0);
    end
    check_state("rst_state", IDLE);

    reset = 1'b0;
    cyc   = 0;
    tick();                                // E1: enter ATTACK
    check_state("att_enter", ATTACK);
    check("att_mflug_e1", mflug_out, 0);
    tick();                                // E2: enable follows state
    check("att_mflug_e2", mflug_out, 1);
    check("att_busy_e2", busy, 1);

    // Attack ramp: +1 every 4 clocks, first at E5, level 15 at E61.
    tick(); tick();
    check("att_lvl0", level, 0);
    tick();
    check("att_lvl1", level, 1);
    for (int lv = 2; lv <= 15; lv++) begin
      repeat (3) tick();
      check("att_hold", level, lv - 1);
      tick();
      check("att_step", level, lv);
    end
    check_state("att_to_sus", SUSTAIN);

    // Full level: 15 of every 16 cycles open.
    cnt = 0;
    repeat (16) begin
      tick();
      cnt += int'(spk);
    end
    check("sus_duty", cnt, 15);
    check("sus_level", level, 15);
    check_state("sus_state", SUSTAIN);

    // Drop play so release starts on a step-aligned edge (E81).
    repeat (3) tick();
    play = 1'b0;
    tick();
    check_state("rel_enter", RELEASE);
    check("rel_lvl15", level, 15);
    for (int lv = 14; lv >= 0; lv--) begin
      repeat (3) tick();
      check("rel_hold", level, lv + 1);
      check("rel_mflug", mflug_out, 1);
      tick();
      check("rel_step", level, lv);
    end
    check_state("rel_to_idle", IDLE);       // E141: same edge as level 0
    check("rel_mflug_e141", mflug_out, 1);
    tick();                                // E142
    check("rel_mflug_drop", mflug_out, 0);
    check("rel_busy_drop", busy, 0);
    repeat (8) begin
      tick();
      check("idle_spk", spk, 0);
      check("idle_level", level, 0);
    end

    // Second attack to full (E151..E211), then release from E215.
    play = 1'b1;
    tick();
    check_state("att2_enter", ATTACK);
    for (int lv = 1; lv <= 15; lv++) begin
      repeat (3) tick();
      check("att2_hold", level, lv - 1);
      tick();
      check("att2_step", level, lv);
    end
    check_state("att2_sus", SUSTAIN);
    repeat (3) tick();
    play = 1'b0;
    tick();
    check_state("rel2_enter", RELEASE);
    for (int lv = 14; lv >= 7; lv--) begin
      repeat (3) tick();
      check("rel2_hold", level, lv + 1);
      tick();
      check("rel2_step", level, lv);
    end

    // Re-trigger at level 7: attack resumes from 7, reaches 15 32 clocks on.
    play = 1'b1;
    tick();
    check_state("retrig_state", ATTACK);
    check("retrig_level", level, 7);
    check("retrig_mflug", mflug_out, 1);
    repeat (2) begin
      tick();
      check("retrig_hold7", level, 7);
      check("retrig_mflug_h", mflug_out, 1);
    end
    tick();
    check("retrig_lvl8", level, 8);
    for (int lv = 9; lv <= 15; lv++) begin
      repeat (3) begin
        tick();
        check("retrig_mflug_r", mflug_out, 1);
      end
      check("retrig_hold", level, lv - 1);
      tick();
      check("retrig_step", level, lv);
    end
    check_state("retrig_sus", SUSTAIN);

    // Square wave toggling every 20 clocks at level 15: spk is the previous
    // cycle's tone gated by (pwm_cnt < 15); pwm_cnt before edge n is (n-1)%16.
    for (int i = 0; i < 80; i++) begin
      if ((i % 20 == 0) && (i > 0)) tone_in = ~tone_in;
      t_prev = tone_in;
      tick();
      exp_spk = t_prev & (((cyc - 1) % 16) < 15);
      check("sq_spk", spk, exp_spk);
    end
    tone_in = 1'b1;

    // Reset mid-sustain clears everything on the next edge, no fade.
    reset = 1'b1;
    tick();
    check_state("mid_rst_state", IDLE);
    check("mid_rst_level", level, 0);
    check("mid_rst_mflug", mflug_out, 0);
    check("mid_rst_spk", spk, 0);
    reset = 1'b0;
    cyc   = 0;

    // Play dropped during attack: release wins, tail from level 1.
    tick();
    check_state("prio_att", ATTACK);
    repeat (3) tick();
    tick();
    check("prio_lvl1", level, 1);
    play = 1'b0;
    tick();                                // E6
    check_state("prio_rel", RELEASE);
    check("prio_rel_lvl", level, 1);
    repeat (2) tick();                     // E8
    check("prio_hold", level, 1);
    tick();                                // E9
    check_state("prio_idle", IDLE);
    check("prio_lvl0", level, 0);
    check("prio_mflug_e9", mflug_out, 1);
    tick();                                // E10
    check("prio_mflug_e10", mflug_out, 0);

`ifdef MUSIC_FADER_VOLCAP_EN
    // Cap at 5: attack stops at 5 (E21).
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc   = 0;
    vol   = 4'd5;
    play  = 1'b1;
    tick();
    check_state("cap_att", ATTACK);
    for (int lv = 1; lv <= 5; lv++) begin
      repeat (3) tick();
      check("cap_hold", level, lv - 1);
      tick();
      check("cap_step", level, lv);
    end
    check_state("cap_sus", SUSTAIN);

    // Lower cap to 2: ramps 4, 3, 2 at 4-clock steps.
    vol = 4'd2;
    for (int lv = 4; lv >= 2; lv--) begin
      repeat (3) tick();
      check("cap_dn_hold", level, lv + 1);
      tick();
      check("cap_dn_step", level, lv);
    end
    check_state("cap_dn_sus", SUSTAIN);

    // Raising cap does not restart attack.
    vol = 4'd9;
    repeat (8) tick();
    check("cap_up_level", level, 2);
    check_state("cap_up_state", SUSTAIN);

    // Cap of 0: straight to sustain at level 0, silent but enabled.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc   = 0;
    vol   = 4'd0;
    tick();
    check_state("cap0_att", ATTACK);
    tick();
    check_state("cap0_sus", SUSTAIN);
    repeat (16) begin
      tick();
      check("cap0_level", level, 0);
      check("cap0_spk", spk, 0);
      check("cap0_mflug", mflug_out, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
